// File: rtl/char_pixel_engine.sv
// ---------------------------------------------------------------------------
// char_pixel_engine
//
// Character/bitmap video fetch and pixel serialiser. For each character cell,
// the engine fetches the code byte and its attribute. It then picks a glyph
// row from the font ROM or the PCG RAM, or it uses the code byte as raw bitmap
// data (gfx mode). It shifts the row out one pixel per pce, and shows the
// cell colour from the attribute.
//
// The CRTC presents vma one cell ahead. The row fetched during cell N is
// therefore displayed during cell N+1 (one-cell display latency).
//
// Optional feature (compile-time macro CURSOR_EN):
//   When CURSOR_EN is defined, a frame counter advances on rising edges of
//   vSync and provides a blinking block cursor. The glyph row of the cell at
//   cursorA is inverted while the blink phase is active. When CURSOR_EN is not
//   defined, cursorA, cursorOn and vSync are ignored.
//
// Ports
//   clock, reset      clock; synchronous active-high reset
//   pce               pixel clock enable (one per pixel)
//   hSync             zeroes the pixel counter (overrides pce)
//   vSync             frame strobe (blink counter, CURSOR_EN only)
//   vma, vra          cell address (one cell ahead), raster row in cell
//   gfx               1 = bitmap mode, code byte is the pixel data
//   pcgEn             PCG bank enables, indexed by code[6]
//   vRd/vAddr/vQ      video RAM read port
//   aRd/aAddr/aQ      attribute RAM read port
//   fRd/fAddr/fQ      font ROM read port
//   pRd/pAddr/pQ      PCG RAM read port
//   cursorA, cursorOn cursor cell address and enable
//   pixel, color      serial pixel out and current cell colour
//   overrun           sticky: a cell start arrived before a fetch completed
// ---------------------------------------------------------------------------
module char_pixel_engine #(
    parameter int CHAR_W     = 8,
    parameter int ROW_BITS   = 3,
    parameter int ADDR_W     = 14,
    parameter int ATTR_AW    = 10,
    parameter int COLOR_W    = 4,
    parameter int BLINK_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pce,
    input  logic                  hSync,
    input  logic                  vSync,
    input  logic [ADDR_W-1:0]     vma,
    input  logic [ROW_BITS-1:0]   vra,
    input  logic                  gfx,
    input  logic [1:0]            pcgEn,
    output logic                  vRd,
    output logic [ADDR_W-1:0]     vAddr,
    input  logic [7:0]            vQ,
    output logic                  aRd,
    output logic [ATTR_AW-1:0]    aAddr,
    input  logic [7:0]            aQ,
    output logic                  fRd,
    output logic [8+ROW_BITS-1:0] fAddr,
    input  logic [CHAR_W-1:0]     fQ,
    output logic                  pRd,
    output logic [7+ROW_BITS-1:0] pAddr,
    input  logic [CHAR_W-1:0]     pQ,
    input  logic [ADDR_W-1:0]     cursorA,
    input  logic                  cursorOn,
    output logic                  pixel,
    output logic [COLOR_W-1:0]    color,
    output logic                  overrun
);

    localparam int PC_W = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(CHAR_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDR  = 2'd1;
    localparam logic [1:0] S_CODE  = 2'd2;
    localparam logic [1:0] S_GLYPH = 2'd3;

    logic [1:0]         state;
    logic [PC_W-1:0]    pc;
    logic [CHAR_W-1:0]  shifter;

    // Holding registers hold the last completed fetch. They are the only
    // source for the shifter and colour load at a cell start, so an aborted
    // fetch never leaks partial data onto the screen.
    logic [CHAR_W-1:0]  hold_glyph;
    logic [COLOR_W-1:0] hold_color;

    // Per-fetch staging: the attribute colour and the glyph source chosen in CODE.
    logic [COLOR_W-1:0] stage_color;
    logic               stage_ds;

    logic               cell_start;
    logic               ds;
    logic               fetch_done;
    logic [CHAR_W-1:0]  load_row;

    assign cell_start = pce && !hSync && (pc == '0);

    // The PCG is selected only for codes with bit 7 set and the matching bank enabled.
    assign ds = vQ[7] && pcgEn[vQ[6]];

    // A fetch completes in CODE (bitmap mode) or in GLYPH. A new cell start on
    // the same clock wins and discards the fetch.
    assign fetch_done = !cell_start &&
                        ((state == S_CODE && gfx) || state == S_GLYPH);

    assign pixel = shifter[CHAR_W-1];

`ifdef CURSOR_EN
    logic                  vs_q;
    logic [BLINK_LOG2-1:0] blink_cnt;
    logic [ADDR_W-1:0]     hold_addr;
    logic                  cursor_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            vs_q      <= 1'b0;
            blink_cnt <= '0;
        end else begin
            vs_q <= vSync;
            if (vSync && !vs_q)
                blink_cnt <= blink_cnt + BLINK_LOG2'(1);
        end
    end

    // vAddr holds the cell address for the entire fetch, so it identifies
    // which cell the completed glyph belongs to.
    always_ff @(posedge clock) begin
        if (reset)
            hold_addr <= '0;
        else if (fetch_done)
            hold_addr <= vAddr;
    end

    assign cursor_hit = cursorOn && blink_cnt[BLINK_LOG2-1] && (hold_addr == cursorA);
    assign load_row   = hold_glyph ^ {CHAR_W{cursor_hit}};
`else
    assign load_row = hold_glyph;

    logic unused_cursor;
    assign unused_cursor = &{1'b0, vSync, cursorA, cursorOn};
`endif

    // The attribute byte carries more bits than the colour field uses.
    logic unused_attr;
    assign unused_attr = &{1'b0, aQ};

    // -----------------------------------------------------------------------
    // Pixel counter and shifter
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            pc      <= '0;
            shifter <= '0;
            color   <= '0;
        end else if (hSync) begin
            // hSync realigns the cell grid; it does not shift or load on this clock.
            pc <= '0;
        end else if (pce) begin
            pc <= (pc == PC_LAST) ? '0 : pc + PC_W'(1);
            if (pc == '0) begin
                shifter <= load_row;
                color   <= hold_color;
            end else begin
                shifter <= {shifter[CHAR_W-2:0], 1'b0};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Fetch FSM. Strobes are registered and are cleared every clock unless
    // they are set again, so each strobe is a single-clock pulse.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            vRd         <= 1'b0;
            aRd         <= 1'b0;
            fRd         <= 1'b0;
            pRd         <= 1'b0;
            vAddr       <= '0;
            aAddr       <= '0;
            fAddr       <= '0;
            pAddr       <= '0;
            stage_color <= '0;
            stage_ds    <= 1'b0;
            hold_glyph  <= '0;
            hold_color  <= '0;
            overrun     <= 1'b0;
        end else begin
            vRd <= 1'b0;
            aRd <= 1'b0;
            fRd <= 1'b0;
            pRd <= 1'b0;

            if (cell_start) begin
                // Any state other than IDLE means the previous fetch did not finish.
                if (state != S_IDLE)
                    overrun <= 1'b1;
                state <= S_ADDR;
                vRd   <= 1'b1;
                aRd   <= 1'b1;
                vAddr <= vma;
                aAddr <= vma[ATTR_AW-1:0];
            end else begin
                case (state)
                    S_ADDR: state <= S_CODE;
                    S_CODE: begin
                        stage_color <= aQ[COLOR_W-1:0];
                        stage_ds    <= ds;
                        if (gfx) begin
                            hold_glyph <= vQ[7 -: CHAR_W];
                            hold_color <= aQ[COLOR_W-1:0];
                            state      <= S_IDLE;
                        end else begin
                            if (ds) begin
                                pRd   <= 1'b1;
                                pAddr <= {vQ[6:0], vra};
                            end else begin
                                fRd   <= 1'b1;
                                fAddr <= {vQ, vra};
                            end
                            state <= S_GLYPH;
                        end
                    end
                    S_GLYPH: begin
                        hold_glyph <= stage_ds ? pQ : fQ;
                        hold_color <= stage_color;
                        state      <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_char_pixel_engine.sv
// ---------------------------------------------------------------------------
// tb_char_pixel_engine
//
// Directed bench for char_pixel_engine with the default geometry
// (CHAR_W=8, ROW_BITS=3). The memory data buses are held at fixed values
// for each scenario. A negedge monitor counts the read strobes and captures
// their addresses.
// ---------------------------------------------------------------------------
module tb_char_pixel_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        pce, hSync, vSync, gfx;
    logic [13:0] vma;
    logic [2:0]  vra;
    logic [1:0]  pcgEn;
    logic        vRd, aRd, fRd, pRd;
    logic [13:0] vAddr;
    logic [9:0]  aAddr;
    logic [10:0] fAddr;
    logic [9:0]  pAddr;
    logic [7:0]  vQ, aQ, fQ, pQ;
    logic [13:0] cursorA;
    logic        cursorOn;
    logic        pixel, overrun;
    logic [3:0]  color;

    always #5 clock = ~clock;

    char_pixel_engine #(
        .CHAR_W(8), .ROW_BITS(3), .ADDR_W(14), .ATTR_AW(10),
        .COLOR_W(4), .BLINK_LOG2(4)
    ) dut (
        .clock(clock), .reset(reset), .pce(pce), .hSync(hSync), .vSync(vSync),
        .vma(vma), .vra(vra), .gfx(gfx), .pcgEn(pcgEn),
        .vRd(vRd), .vAddr(vAddr), .vQ(vQ),
        .aRd(aRd), .aAddr(aAddr), .aQ(aQ),
        .fRd(fRd), .fAddr(fAddr), .fQ(fQ),
        .pRd(pRd), .pAddr(pAddr), .pQ(pQ),
        .cursorA(cursorA), .cursorOn(cursorOn),
        .pixel(pixel), .color(color), .overrun(overrun)
    );

    int n_chk  = 0;
    int n_pass = 0;

    int          v_cnt, a_cnt, f_cnt, p_cnt;
    logic [13:0] v_cap;
    logic [9:0]  a_cap;
    logic [10:0] f_cap;
    logic [9:0]  p_cap;

    always @(negedge clock) begin
        if (vRd) begin v_cnt++; v_cap = vAddr; end
        if (aRd) begin a_cnt++; a_cap = aAddr; end
        if (fRd) begin f_cnt++; f_cap = fAddr; end
        if (pRd) begin p_cnt++; p_cap = pAddr; end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clr_mon();
        v_cnt = 0; a_cnt = 0; f_cnt = 0; p_cnt = 0;
        v_cap = '0; a_cap = '0; f_cap = '0; p_cap = '0;
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    // One pixel, with pce asserted every second clock.
    task automatic pce_step(output logic px);
        pce = 1'b1; step();
        pce = 1'b0; px = pixel;
        step();
    endtask

    // One full cell, with pixels collected MSB first.
    task automatic run_cell(output logic [7:0] bits);
        logic p;
        for (int i = 0; i < 8; i++) begin
            pce_step(p);
            bits[7-i] = p;
        end
    endtask

    logic [7:0] bits;
    logic [7:0] cur_exp;

    initial begin
        reset = 1'b1; pce = 1'b0; hSync = 1'b0; vSync = 1'b0; gfx = 1'b0;
        vma = 14'h0123; vra = 3'd2; pcgEn = 2'b00;
        vQ = 8'h00; aQ = 8'h00; fQ = 8'h00; pQ = 8'h00;
        cursorA = 14'h0000; cursorOn = 1'b0;
        clr_mon();

        // Reset state
        repeat (3) step();
        chk("rst_pixel", pixel, 1'b0);
        chk("rst_color", color, 4'h0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_strobes", {vRd, aRd, fRd, pRd}, 4'b0000);
        reset = 1'b0;

        // Reset during a fetch clears strobes and idles the FSM
        pce = 1'b1; step(); pce = 1'b0;
        chk("start_vrd", {vRd, aRd}, 2'b11);
        reset = 1'b1; step();
        chk("midrst_strobes", {vRd, aRd, fRd, pRd}, 4'b0000);
        reset = 1'b0; step();

        // Font path
        vQ = 8'h41; aQ = 8'h05; fQ = 8'h3C; pQ = 8'h81; gfx = 1'b0; pcgEn = 2'b00;
        clr_mon();
        run_cell(bits);
        chk("first_cell_blank", bits, 8'h00);
        chk("font_vaddr", {v_cnt[3:0], v_cap}, {4'd1, 14'h0123});
        chk("font_aaddr", {a_cnt[3:0], a_cap}, {4'd1, 10'h123});
        chk("font_fRd", {f_cnt[3:0], f_cap}, {4'd1, 11'h20A});
        chk("font_no_pRd", p_cnt, 0);
        run_cell(bits);
        chk("font_pixels", bits, 8'h3C);
        chk("font_color", color, 4'h5);
        chk("font_no_overrun", overrun, 1'b0);

        // PCG path (code[7]=1, code[6]=1, bank 1 enabled)
        vQ = 8'hC2; aQ = 8'hA9; pcgEn = 2'b10;
        run_cell(bits);
        clr_mon();
        run_cell(bits);
        chk("pcg_pRd", {p_cnt[3:0], p_cap}, {4'd1, 10'h212});
        chk("pcg_no_fRd", f_cnt, 0);
        chk("pcg_pixels", bits, 8'h81);
        chk("pcg_color", color, 4'h9);

        // Same code with bank disabled falls back to the font ROM
        pcgEn = 2'b00; aQ = 8'h03;
        run_cell(bits);
        clr_mon();
        run_cell(bits);
        chk("nopcg_fRd", {f_cnt[3:0], f_cap}, {4'd1, 11'h612});
        chk("nopcg_no_pRd", p_cnt, 0);
        chk("nopcg_pixels", bits, 8'h3C);

        // Bitmap mode
        gfx = 1'b1; vQ = 8'hA5; aQ = 8'h0E;
        run_cell(bits);
        clr_mon();
        run_cell(bits);
        chk("gfx_no_glyph_rd", f_cnt + p_cnt, 0);
        chk("gfx_vRd", v_cnt, 1);
        chk("gfx_pixels", bits, 8'hA5);
        chk("gfx_color", color, 4'hE);
        gfx = 1'b0;

        // A 4-clock cell period is the fastest that completes without overrun
        pce = 1'b1; step(); pce = 1'b0;
        step(); step();
        hSync = 1'b1; step(); hSync = 1'b0;
        pce = 1'b1; step(); pce = 1'b0;
        repeat (4) step();
        chk("four_clk_no_overrun", overrun, 1'b0);
        hSync = 1'b1; step(); hSync = 1'b0;

        // A 2-clock cell period restarts the fetch and sets sticky overrun
        pce = 1'b1; step(); pce = 1'b0;
        hSync = 1'b1; step(); hSync = 1'b0;
        pce = 1'b1; step(); pce = 1'b0;
        chk("overrun_set", overrun, 1'b1);
        repeat (10) step();
        chk("overrun_sticky", overrun, 1'b1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("overrun_cleared", overrun, 1'b0);

        // Cursor: 8 frames put the blink MSB high
        vQ = 8'h41; aQ = 8'h05; fQ = 8'h3C; cursorA = vma; cursorOn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vSync = 1'b1; step();
            vSync = 1'b0; step();
        end
        run_cell(bits);
        run_cell(bits);
`ifdef CURSOR_EN
        cur_exp = 8'hC3;
`else
        cur_exp = 8'h3C;
`endif
        chk("cursor_pixels", bits, cur_exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
